// File: rtl/freq_div_pkg.sv
// Shared constants for the programmable divide-by-N clock divider.
// Optional period counter enabled by FREQ_DIVIDER_N_PERIOD_CNT_EN.
package freq_div_pkg;
    localparam int CNT_W_DEF    = 8;
    localparam int DIV_RST_VAL  = 3;
    localparam int DIV_MIN      = 2;
    localparam int PERIOD_CNT_W = 16;
endpackage

// File: rtl/freq_divider_n_if.sv
// Control/status bundle of the divide-by-N divider.
// period_cnt exists only with FREQ_DIVIDER_N_PERIOD_CNT_EN.
interface freq_divider_n_if
    import freq_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             start;
    logic [CNT_W-1:0] div_val;
    logic             div_load;
    logic             div_busy;
    logic             div_err;
    logic [CNT_W-1:0] count;
    logic             div_out;
    logic             tick;
`ifdef FREQ_DIVIDER_N_PERIOD_CNT_EN
    logic [PERIOD_CNT_W-1:0] period_cnt;

    modport master (
        output start, div_val, div_load,
        input  div_busy, div_err, count,
        input  div_out, tick, period_cnt
    );
    modport slave (
        input  start, div_val, div_load,
        output div_busy, div_err, count,
        output div_out, tick, period_cnt
    );
`else
    modport master (
        output start, div_val, div_load,
        input  div_busy, div_err, count,
        input  div_out, tick
    );
    modport slave (
        input  start, div_val, div_load,
        output div_busy, div_err, count,
        output div_out, tick
    );
`endif
endinterface

// File: rtl/freq_div_shadow.sv
// Shadow divisor register: accepts or rejects loads, holds the
// pending value and its busy flag until the top applies it.
module freq_div_shadow
    import freq_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_val,
    input  logic             apply,
    output logic [CNT_W-1:0] n_sh,
    output logic             busy,
    output logic             err
);
    logic accept;

    // apply needs busy=1, so it can never collide with an accept
    assign accept = div_load && !busy
                 && (div_val >= CNT_W'(DIV_MIN));

    always_ff @(posedge clk) begin
        if (rst) begin
            n_sh <= CNT_W'(DIV_RST_VAL);
            busy <= 1'b0;
            err  <= 1'b0;
        end else begin
            err <= div_load && !accept;
            if (accept) begin
                n_sh <= div_val;
                busy <= 1'b1;
            end else if (apply) begin
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/freq_divider_n.sv
// Programmable divide-by-N clock divider with shadowed divisor.
// Define FREQ_DIVIDER_N_PERIOD_CNT_EN to add the 16-bit period_cnt.
module freq_divider_n
    import freq_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input logic              clk,
    input logic              rst,
    freq_divider_n_if.slave  bus
);
    logic [CNT_W-1:0] n_act;
    logic [CNT_W-1:0] n_nxt;
    logic [CNT_W-1:0] n_sh;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             busy;
    logic             err;
    logic             wrap;
    logic             apply;
    logic             div_q;

    freq_div_shadow #(
        .CNT_W (CNT_W)
    ) u_shadow (
        .clk      (clk),
        .rst      (rst),
        .div_load (bus.div_load),
        .div_val  (bus.div_val),
        .apply    (apply),
        .n_sh     (n_sh),
        .busy     (busy),
        .err      (err)
    );

    assign wrap  = (cnt == n_act - CNT_W'(1));
    assign apply = busy && (!bus.start || wrap);

    always_comb begin
        cnt_nxt = '0;
        n_nxt   = n_act;
        if (bus.start && !wrap)
            cnt_nxt = cnt + CNT_W'(1);
        if (apply)
            n_nxt = n_sh;
    end

    // div_out registered from next-state so it lines up with count
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            n_act <= CNT_W'(DIV_RST_VAL);
            div_q <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            n_act <= n_nxt;
            div_q <= bus.start && (cnt_nxt < (n_nxt >> 1));
        end
    end

    assign bus.count    = cnt;
    assign bus.div_out  = div_q;
    assign bus.tick     = bus.start && wrap;
    assign bus.div_busy = busy;
    assign bus.div_err  = err;

`ifdef FREQ_DIVIDER_N_PERIOD_CNT_EN
    logic [PERIOD_CNT_W-1:0] pcnt;

    always_ff @(posedge clk) begin
        if (rst)
            pcnt <= '0;
        else if (bus.tick)
            pcnt <= pcnt + PERIOD_CNT_W'(1);
    end

    assign bus.period_cnt = pcnt;
`endif
endmodule
